// File: rtl/if_fetch_ctrl.sv
// Instruction fetch bus master: one outstanding request to a variable-latency
// instruction memory, a 1-entry skid for decode back-pressure, and flush/misalign handling.
module if_fetch_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] PCF,
    input  logic            StallD,
    input  logic            FlushF,
    output logic            IM_REQ,
    output logic [XLEN-1:0] IM_ADDR,
    input  logic            IM_GNT,
    input  logic            IM_RVALID,
    input  logic [XLEN-1:0] IM_RDATA,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCOutF,
    output logic            InstrValidF,
    output logic            PCEN,
    output logic            MisalignF
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } slot_t;

    state_t          state, state_nxt;
    logic            drop, drop_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;
    slot_t           skid, skid_nxt;
    logic            skid_valid, skid_valid_nxt;
    logic [XLEN-1:0] instr_nxt;
    logic [XLEN-1:0] pcout_nxt;
    logic            valid_nxt;
    logic            aligned;
    logic            slot_free;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_REQ;
            drop        <= 1'b0;
            pend_pc     <= '0;
            skid        <= '0;
            skid_valid  <= 1'b0;
            InstrF      <= NOP_INSTR;
            PCOutF      <= '0;
            InstrValidF <= 1'b0;
        end else begin
            state       <= state_nxt;
            drop        <= drop_nxt;
            pend_pc     <= pend_pc_nxt;
            skid        <= skid_nxt;
            skid_valid  <= skid_valid_nxt;
            InstrF      <= instr_nxt;
            PCOutF      <= pcout_nxt;
            InstrValidF <= valid_nxt;
        end
    end

    // Next-state, slot update and combinational bus/PC outputs
    always_comb begin
        state_nxt      = state;
        drop_nxt       = drop;
        pend_pc_nxt    = pend_pc;
        skid_nxt       = skid;
        skid_valid_nxt = skid_valid;
        instr_nxt      = InstrF;
        pcout_nxt      = PCOutF;
        valid_nxt      = InstrValidF;
        IM_REQ         = 1'b0;
        IM_ADDR        = PCF;
        PCEN           = 1'b0;
        MisalignF      = 1'b0;
        aligned        = (PCF[1:0] == 2'b00);
        slot_free      = !InstrValidF || !StallD;

        // Decode consumed the slot and nothing new arrives: bubble
        if (!StallD) begin
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
        end

        case (state)
            S_REQ: begin
                IM_REQ    = !FlushF && aligned;
                MisalignF = !aligned && !FlushF;
                if (IM_GNT && IM_REQ) begin
                    pend_pc_nxt = PCF;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (IM_RVALID) begin
                    if (!drop && !FlushF) begin
                        PCEN = 1'b1;
                        if (slot_free) begin
                            instr_nxt = IM_RDATA;
                            pcout_nxt = pend_pc;
                            valid_nxt = 1'b1;
                            state_nxt = S_REQ;
                        end else begin
                            skid_nxt       = '{instr: IM_RDATA, pc: pend_pc};
                            skid_valid_nxt = 1'b1;
                            state_nxt      = S_HOLD;
                        end
                    end else begin
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end
                end else if (FlushF) begin
                    // Response still owed by memory; swallow it when it lands
                    drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (!StallD && skid_valid) begin
                    instr_nxt      = skid.instr;
                    pcout_nxt      = skid.pc;
                    valid_nxt      = 1'b1;
                    skid_valid_nxt = 1'b0;
                    state_nxt      = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase

        // Redirect wins over every slot/skid load
        if (FlushF) begin
            valid_nxt      = 1'b0;
            instr_nxt      = NOP_INSTR;
            skid_valid_nxt = 1'b0;
            if (state == S_HOLD) begin
                state_nxt = S_REQ;
            end
        end

        if (!RST) begin
            IM_REQ    = 1'b0;
            PCEN      = 1'b0;
            MisalignF = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl: fetch latency, back-to-back,
// skid under stall, flush in WAIT/with RVALID/in HOLD, misalign and mid-WAIT reset.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PCF;
    logic        StallD;
    logic        FlushF;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_GNT;
    logic        IM_RVALID;
    logic [31:0] IM_RDATA;
    logic [31:0] InstrF;
    logic [31:0] PCOutF;
    logic        InstrValidF;
    logic        PCEN;
    logic        MisalignF;

    int checks = 0;
    int errors = 0;
    int pcen_cnt = 0;
    int snap;

    if_fetch_ctrl #(.XLEN(32), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RST(RST), .PCF(PCF), .StallD(StallD), .FlushF(FlushF),
        .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_GNT(IM_GNT), .IM_RVALID(IM_RVALID),
        .IM_RDATA(IM_RDATA), .InstrF(InstrF), .PCOutF(PCOutF),
        .InstrValidF(InstrValidF), .PCEN(PCEN), .MisalignF(MisalignF)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (PCEN === 1'b1) pcen_cnt <= pcen_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One granted request followed by a response in the next cycle
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        PCF = pc; IM_GNT = 1'b1; IM_RVALID = 1'b0;
        tick;
        IM_GNT = 1'b0; IM_RVALID = 1'b1; IM_RDATA = data;
        tick;
        IM_RVALID = 1'b0; PCF = pc + 32'd4;
        #1;
    endtask

    initial begin
        RST = 1'b0; PCF = '0; StallD = 1'b0; FlushF = 1'b0;
        IM_GNT = 1'b0; IM_RVALID = 1'b0; IM_RDATA = '0;
        tick; tick;
        check("rst_instr", InstrF, NOP);
        check("rst_pcout", PCOutF, 32'h0);
        check("rst_valid", 32'(InstrValidF), 32'h0);
        check("rst_req", 32'(IM_REQ), 32'h0);
        check("rst_pcen", 32'(PCEN), 32'h0);

        // First fetch: latency and request/response handshake
        RST = 1'b1; PCF = 32'h0; IM_GNT = 1'b1;
        #1;
        check("t1_req", 32'(IM_REQ), 32'h1);
        check("t1_addr", IM_ADDR, 32'h0);
        tick;
        IM_GNT = 1'b0; IM_RVALID = 1'b1; IM_RDATA = 32'h00500093;
        #1;
        check("t1_wait_req", 32'(IM_REQ), 32'h0);
        check("t1_pcen", 32'(PCEN), 32'h1);
        tick;
        IM_RVALID = 1'b0; PCF = 32'h4;
        #1;
        check("t1_instr", InstrF, 32'h00500093);
        check("t1_pcout", PCOutF, 32'h0);
        check("t1_valid", 32'(InstrValidF), 32'h1);
        check("t1_next_req", 32'(IM_REQ), 32'h1);

        // Back-to-back fetches at 0x0/0x4/0x8
        snap = pcen_cnt;
        fetch(32'h0, 32'h11111111);
        check("b2b0_instr", InstrF, 32'h11111111);
        check("b2b0_pc", PCOutF, 32'h0);
        fetch(32'h4, 32'h22222222);
        check("b2b1_instr", InstrF, 32'h22222222);
        check("b2b1_pc", PCOutF, 32'h4);
        fetch(32'h8, 32'h33333333);
        check("b2b2_instr", InstrF, 32'h33333333);
        check("b2b2_pc", PCOutF, 32'h8);
        check("b2b_valid", 32'(InstrValidF), 32'h1);
        check("b2b_pcen_cnt", 32'(pcen_cnt - snap), 32'd3);

        // Stall with a valid slot: second response parks in the skid
        StallD = 1'b1;
        fetch(32'hC, 32'h44444444);
        check("skid_req", 32'(IM_REQ), 32'h0);
        check("skid_instr_hold", InstrF, 32'h33333333);
        check("skid_pc_hold", PCOutF, 32'h8);
        tick;
        check("skid_instr_hold2", InstrF, 32'h33333333);
        StallD = 1'b0; PCF = 32'h10;
        tick;
        check("skid_out_instr", InstrF, 32'h44444444);
        check("skid_out_pc", PCOutF, 32'hC);
        check("skid_out_valid", 32'(InstrValidF), 32'h1);
        check("skid_out_req", 32'(IM_REQ), 32'h1);
        check("skid_out_addr", IM_ADDR, 32'h10);

        // Flush in WAIT; response two cycles later is dropped
        IM_GNT = 1'b1;
        tick;
        IM_GNT = 1'b0; FlushF = 1'b1;
        tick;
        FlushF = 1'b0; PCF = 32'h40;
        tick;
        snap = pcen_cnt;
        IM_RVALID = 1'b1; IM_RDATA = 32'hDEADBEEF;
        #1;
        check("flw_pcen", 32'(PCEN), 32'h0);
        tick;
        IM_RVALID = 1'b0;
        #1;
        check("flw_valid", 32'(InstrValidF), 32'h0);
        check("flw_instr", InstrF, NOP);
        check("flw_req", 32'(IM_REQ), 32'h1);
        check("flw_addr", IM_ADDR, 32'h40);
        check("flw_pcen_cnt", 32'(pcen_cnt - snap), 32'd0);

        // Flush coincident with the response
        IM_GNT = 1'b1;
        tick;
        IM_GNT = 1'b0; IM_RVALID = 1'b1; IM_RDATA = 32'hBAD0BAD0; FlushF = 1'b1;
        #1;
        check("flr_pcen", 32'(PCEN), 32'h0);
        tick;
        IM_RVALID = 1'b0; FlushF = 1'b0;
        #1;
        check("flr_req", 32'(IM_REQ), 32'h1);
        check("flr_valid", 32'(InstrValidF), 32'h0);

        // Flush while in HOLD
        fetch(32'h44, 32'h55555555);
        check("flh_pre_instr", InstrF, 32'h55555555);
        StallD = 1'b1;
        fetch(32'h48, 32'h66666666);
        check("flh_hold_req", 32'(IM_REQ), 32'h0);
        snap = pcen_cnt;
        FlushF = 1'b1;
        tick;
        FlushF = 1'b0;
        #1;
        check("flh_req", 32'(IM_REQ), 32'h1);
        check("flh_valid", 32'(InstrValidF), 32'h0);
        check("flh_instr", InstrF, NOP);
        check("flh_pcen_cnt", 32'(pcen_cnt - snap), 32'd0);
        StallD = 1'b0;
        tick;
        check("flh_skid_gone", 32'(InstrValidF), 32'h0);

        // Misaligned PC
        snap = pcen_cnt;
        PCF = 32'h2; IM_GNT = 1'b1;
        #1;
        check("mis_flag", 32'(MisalignF), 32'h1);
        check("mis_req", 32'(IM_REQ), 32'h0);
        tick;
        check("mis_stay", 32'(MisalignF), 32'h1);
        FlushF = 1'b1;
        #1;
        check("mis_flush_flag", 32'(MisalignF), 32'h0);
        tick;
        FlushF = 1'b0; PCF = 32'h50; IM_GNT = 1'b0;
        #1;
        check("mis_redirect_req", 32'(IM_REQ), 32'h1);
        check("mis_pcen_cnt", 32'(pcen_cnt - snap), 32'd0);

        // Reset asserted mid-WAIT
        StallD = 1'b1;
        fetch(32'h50, 32'h77777777);
        check("rw_pre_valid", 32'(InstrValidF), 32'h1);
        PCF = 32'h54; IM_GNT = 1'b1;
        tick;
        IM_GNT = 1'b0; RST = 1'b0;
        #1;
        check("rw_req_low", 32'(IM_REQ), 32'h0);
        tick;
        check("rw_instr", InstrF, NOP);
        check("rw_pcout", PCOutF, 32'h0);
        check("rw_valid", 32'(InstrValidF), 32'h0);
        RST = 1'b1; StallD = 1'b0;
        #1;
        check("rw_state_req", 32'(IM_REQ), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
